// File: rtl/mem_port_arbiter.sv
// Five-way memory port arbiter driving the IorD address mux; IDLE/ACCESS/DONE FSM, all outputs registered.
// Optional MEM_ARB_FAIRNESS_EN masks the last-served requester at the next arbitration.
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] req,
    input  logic [4:0] we_req,
    output logic [4:0] grant,
    output logic [4:0] done,
    output logic [2:0] iord_sel,
    output logic       mem_wr,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] grant_q, grant_d;
    logic [4:0] done_q, done_d;
    logic [2:0] iord_sel_q, iord_sel_d;
    logic       mem_wr_q, mem_wr_d;
    logic       busy_q, busy_d;

    logic [4:0] cand;
    logic [4:0] win_oh;
    logic [2:0] win_idx;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [4:0] mask_q, mask_d;
    logic [4:0] masked_req;

    // Fall back to the full request set when only the masked requester is asking.
    assign masked_req = req & ~mask_q;
    assign cand       = (masked_req != 5'd0) ? masked_req : req;
`else
    assign cand = req;
`endif

    // Fixed priority: the highest set index wins because it is visited last.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < 5; i++) begin
            if (cand[i]) begin
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_idx    = 3'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        done_d     = '0;
        iord_sel_d = iord_sel_q;
        mem_wr_d   = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
        mask_d     = mask_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (req != 5'd0) begin
                    state_d    = ACCESS;
                    grant_d    = win_oh;
                    iord_sel_d = win_idx;
                    mem_wr_d   = |(we_req & win_oh);
                    cnt_d      = '0;
`ifdef MEM_ARB_FAIRNESS_EN
                    // The previous mask is consumed here and replaced by this winner.
                    mask_d     = win_oh;
`endif
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            iord_sel_q <= '0;
            mem_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            iord_sel_q <= iord_sel_d;
            mem_wr_q   <= mem_wr_d;
            busy_q     <= busy_d;
`ifdef MEM_ARB_FAIRNESS_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign iord_sel = iord_sel_q;
    assign mem_wr   = mem_wr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, write pulse, priority order, async reset, starvation/fairness.
module tb_mem_port_arbiter;

    localparam int WAIT = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] req;
    logic [4:0] we_req;
    logic [4:0] grant;
    logic [4:0] done;
    logic [2:0] iord_sel;
    logic       mem_wr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .we_req   (we_req),
        .grant    (grant),
        .done     (done),
        .iord_sel (iord_sel),
        .mem_wr   (mem_wr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One full access starting from an IDLE cycle; req_after is applied after the first grant cycle.
    task automatic run_access(input string tag, input logic [4:0] r, input logic [4:0] w,
                              input logic [4:0] exp_g, input logic [2:0] exp_sel,
                              input logic exp_wr, input logic [4:0] req_after);
        req    = r;
        we_req = w;
        @(negedge clk);
        chk({tag, " grant c1"}, 32'(grant), 32'(exp_g));
        chk({tag, " sel c1"}, 32'(iord_sel), 32'(exp_sel));
        chk({tag, " wr c1"}, 32'(mem_wr), 32'(exp_wr));
        chk({tag, " busy c1"}, 32'(busy), 32'd1);
        chk({tag, " done c1"}, 32'(done), 32'd0);
        req    = req_after;
        we_req = 5'b00000;
        for (int c = 2; c <= WAIT; c++) begin
            @(negedge clk);
            chk({tag, " grant acc"}, 32'(grant), 32'(exp_g));
            chk({tag, " sel acc"}, 32'(iord_sel), 32'(exp_sel));
            chk({tag, " wr acc"}, 32'(mem_wr), 32'd0);
            chk({tag, " done acc"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        chk({tag, " grant done"}, 32'(grant), 32'(exp_g));
        chk({tag, " done pulse"}, 32'(done), 32'(exp_g));
        chk({tag, " wr done"}, 32'(mem_wr), 32'd0);
        @(negedge clk);
        chk({tag, " grant idle"}, 32'(grant), 32'd0);
        chk({tag, " done idle"}, 32'(done), 32'd0);
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        chk({tag, " sel hold"}, 32'(iord_sel), 32'(exp_sel));
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 5'b00000;
        we_req  = 5'b00000;
        #2;
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sel", 32'(iord_sel), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single low-priority read; req dropped after first cycle must not abort it.
        run_access("r0", 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b0, 5'b00000);
        // Write from requester 1: mem_wr only in the first grant cycle.
        run_access("w1", 5'b00010, 5'b00010, 5'b00010, 3'd1, 1'b1, 5'b00000);
        // Simultaneous 4,2,1: served in descending order, one IDLE cycle apart.
        run_access("p4", 5'b10110, 5'b00000, 5'b10000, 3'd4, 1'b0, 5'b00110);
        run_access("p2", 5'b00110, 5'b00000, 5'b00100, 3'd2, 1'b0, 5'b00010);
        run_access("p1", 5'b00010, 5'b00000, 5'b00010, 3'd1, 1'b0, 5'b00000);

        // Reset in the second ACCESS cycle clears everything immediately.
        req    = 5'b01000;
        we_req = 5'b01000;
        @(negedge clk);
        chk("mid grant c1", 32'(grant), 32'b01000);
        chk("mid wr c1", 32'(mem_wr), 32'd1);
        req    = 5'b00000;
        we_req = 5'b00000;
        @(negedge clk);
        chk("mid grant c2", 32'(grant), 32'b01000);
        reset_n = 1'b0;
        #1;
        chk("mid rst grant", 32'(grant), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst wr", 32'(mem_wr), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst sel", 32'(iord_sel), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post rst no done", 32'(done), 32'd0);
            chk("post rst idle", 32'(busy), 32'd0);
        end

        // Constant 11000: starvation without the fairness option, alternation with it.
        run_access("f1", 5'b11000, 5'b00000, 5'b10000, 3'd4, 1'b0, 5'b11000);
`ifdef MEM_ARB_FAIRNESS_EN
        run_access("f2", 5'b11000, 5'b00000, 5'b01000, 3'd3, 1'b0, 5'b11000);
`else
        run_access("f2", 5'b11000, 5'b00000, 5'b10000, 3'd4, 1'b0, 5'b11000);
`endif
        run_access("f3", 5'b11000, 5'b00000, 5'b10000, 3'd4, 1'b0, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory access length in cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  5  per-requester access request; bit i requests address source i of the IorD mux (0 PC, 1 ALUOut, 2..4 fixed/exception addresses).
REQ-005 we_req  input  5  per-requester write intent; sampled only together with req.
REQ-006 grant  output  5  one-hot grant; all-zero when idle.
REQ-007 done  output  5  one-cycle completion pulse to the granted requester.
REQ-008 iord_sel  output  3  selector driven to the IorD mux; value 0..4 only.
REQ-009 mem_wr  output  1  memory write enable.
REQ-010 busy  output  1  high in every non-IDLE state.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, ACCESS and DONE; all outputs SHALL be registered.
REQ-012 In IDLE with req non-zero, the next edge SHALL pick the winner by fixed priority (bit 4 highest, bit 0 lowest), enter ACCESS, set grant to the winner's one-hot, set iord_sel to the winner index, set mem_wr to we_req[winner], and clear the cycle counter.
REQ-013 In IDLE with req zero, the block SHALL stay in IDLE with grant=0, done=0 and mem_wr=0; iord_sel SHALL hold its last value.
REQ-014 In ACCESS, each edge SHALL increment the counter, and mem_wr SHALL be high only in the first ACCESS cycle.
REQ-015 In ACCESS, iord_sel and grant SHALL stay stable.
REQ-016 When the counter equals WAIT_CYCLES-1 at an edge, the block SHALL enter DONE and assert done[winner] for exactly one cycle, with grant still held.
REQ-017 From DONE, the next edge SHALL return to IDLE and clear grant and done; a new arbitration SHALL happen no earlier than the IDLE cycle.
REQ-018 Latency: request sampled at edge E gives grant high in cycles E+1..E+1+WAIT_CYCLES, done in cycle E+1+WAIT_CYCLES, and the next grant no earlier than E+3+WAIT_CYCLES.
REQ-019 Deassertion of req or changes to we_req during ACCESS or DONE SHALL be ignored; the access SHALL complete.
REQ-020 Requests arriving during ACCESS or DONE SHALL wait; nothing is queued beyond the level of req.
REQ-021 At most one bit of grant and one bit of done SHALL ever be high.

Reset
REQ-022 On reset_n low, the block SHALL immediately enter IDLE with grant=0, done=0, mem_wr=0, busy=0, iord_sel=0 and counter=0, including mid-access.
REQ-023 The first arbitration SHALL occur on the first rising edge after reset_n is high.

Configuration
REQ-024 With MEM_ARB_FAIRNESS_EN defined, the last-served requester SHALL be masked at the next arbitration if any other req bit is set; the mask SHALL clear after that arbitration and at reset.
REQ-025 Without MEM_ARB_FAIRNESS_EN, pure fixed priority SHALL apply, and a continuously requesting higher index SHALL starve lower ones.

Verification
REQ-026 WAIT_CYCLES=2, req=00001, we_req=0 at edge 0 -> grant=00001 in cycles 1-3, iord_sel=0, mem_wr=0, done=00001 in cycle 3 only, busy low in cycle 4.
REQ-027 req=00010, we_req=00010 -> mem_wr high in the first grant cycle only, iord_sel=1 for the whole access.
REQ-028 req=10110 simultaneously -> grant=10000 and iord_sel=4; then bit 2 is served, then bit 1, each separated by one IDLE cycle.
REQ-029 reset_n pulsed low in the second ACCESS cycle -> grant, done, mem_wr, busy and iord_sel are all zero immediately; no done pulse is issued.
REQ-030 req=11000 held constant -> without the macro, grant stays 10000 every access; with MEM_ARB_FAIRNESS_EN, grants alternate 10000 and 01000.
